// File: rtl/race_score_keeper.sv
// ============================================================================
// Module   : race_score_keeper
// Purpose  : Race FSM plus score/time registers for the HUD number overlays.
//            Score and time only change at vsync_tick frame boundaries.
//            Optional macro RACE_HIGH_SCORE_EN adds a high_score output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module race_score_keeper #(
  parameter int MAX_SCORE      = 99,
  parameter int BONUS_PTS      = 5,
  parameter int GAME_TIME      = 60,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       bonus,
  input  logic       crash,
  input  logic       vsync_tick,
  output logic [7:0] score,
  output logic [7:0] time_left,
`ifdef RACE_HIGH_SCORE_EN
  output logic [7:0] high_score,
`endif
  output logic       running,
  output logic       game_over
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_over = 2'd2;

  localparam logic [7:0] c_max_score = 8'(MAX_SCORE);
  localparam logic [8:0] c_bonus_pts = 9'(BONUS_PTS);
  localparam logic [7:0] c_game_time = 8'(GAME_TIME);
  localparam logic [7:0] c_last_frm  = 8'(FRAMES_PER_SEC - 1);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       w_running_next;
  logic       w_game_over_next;

  logic [7:0] r_pending;
  logic [7:0] r_frame_cnt;

  logic [8:0] w_contrib;
  logic [7:0] w_contrib_sat;
  logic [8:0] w_pend_sum;
  logic [7:0] w_pend_acc;
  logic [8:0] w_score_sum;
  logic [7:0] w_score_commit;
  logic       w_last_frame;
  logic       w_timeout;

  // Points earned this cycle, and the saturating accumulator/commit values.
  always_comb begin
    w_contrib      = {8'd0, hit} + (bonus ? c_bonus_pts : 9'd0);
    w_contrib_sat  = w_contrib[8] ? 8'hFF : w_contrib[7:0];
    w_pend_sum     = {1'b0, r_pending} + w_contrib;
    w_pend_acc     = w_pend_sum[8] ? 8'hFF : w_pend_sum[7:0];
    w_score_sum    = {1'b0, score} + {1'b0, r_pending};
    w_score_commit = (w_score_sum > {1'b0, c_max_score}) ? c_max_score : w_score_sum[7:0];
    w_last_frame   = (r_frame_cnt == c_last_frm);
    w_timeout      = vsync_tick && w_last_frame && (time_left == 8'd1);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state   <= c_idle;
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      running   <= w_running_next;
      game_over <= w_game_over_next;
    end
  end

  // Crash takes priority over a coincident timeout tick.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (start) w_state_next = c_run;
      c_run:   if (crash || w_timeout) w_state_next = c_over;
      c_over:  if (start) w_state_next = c_run;
      default: w_state_next = c_idle;
    endcase
  end

  always_comb begin
    w_running_next   = (w_state_next == c_run);
    w_game_over_next = (w_state_next == c_over);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      score       <= 8'd0;
      time_left   <= c_game_time;
      r_pending   <= 8'd0;
      r_frame_cnt <= 8'd0;
    end else if (r_state == c_run) begin
      if (crash) begin
        r_pending <= 8'd0;
      end else if (vsync_tick) begin
        score     <= w_score_commit;
        r_pending <= w_contrib_sat;
        if (w_last_frame) begin
          r_frame_cnt <= 8'd0;
          time_left   <= time_left - 8'd1;
        end else begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
      end else begin
        r_pending <= w_pend_acc;
      end
    end else if (start) begin
      score       <= 8'd0;
      time_left   <= c_game_time;
      r_pending   <= 8'd0;
      r_frame_cnt <= 8'd0;
    end
  end

`ifdef RACE_HIGH_SCORE_EN
  logic [7:0] w_final_score;

  always_comb begin
    w_final_score = crash ? score : w_score_commit;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      high_score <= 8'd0;
    end else if ((r_state == c_run) && (w_state_next == c_over) &&
                 (w_final_score > high_score)) begin
      high_score <= w_final_score;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_race_score_keeper.sv
// ============================================================================
// Module   : tb_race_score_keeper
// Purpose  : Randomized bench for race_score_keeper against a score/time model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_race_score_keeper;

  localparam int MAXS = 99;
  localparam int BPTS = 5;
  localparam int GT   = 3;
  localparam int FPS  = 4;

  logic       clk = 1'b0;
  logic       rst, start, hit, bonus, crash, vsync_tick;
  logic [7:0] score, time_left;
  logic       running, game_over;
`ifdef RACE_HIGH_SCORE_EN
  logic [7:0] high_score;
`endif

  always #5 clk = ~clk;

  race_score_keeper #(
    .MAX_SCORE(MAXS), .BONUS_PTS(BPTS), .GAME_TIME(GT), .FRAMES_PER_SEC(FPS)
  ) dut (
    .pclk(clk), .rst(rst), .start(start), .hit(hit), .bonus(bonus),
    .crash(crash), .vsync_tick(vsync_tick), .score(score), .time_left(time_left),
`ifdef RACE_HIGH_SCORE_EN
    .high_score(high_score),
`endif
    .running(running), .game_over(game_over)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 racing, 2 finished.
  int m_phase = 0, m_score = 0, m_time = GT, m_pend = 0, m_frames = 0, m_hs = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic finish_race();
    m_phase = 2;
    if (m_score > m_hs) m_hs = m_score;
  endtask

  task automatic model_step(input bit r, s, h, b, c, v);
    int pts;
    pts = (h ? 1 : 0) + (b ? BPTS : 0);
    if (r) begin
      m_phase = 0; m_score = 0; m_time = GT; m_pend = 0; m_frames = 0; m_hs = 0;
    end else if (m_phase != 1) begin
      if (s) begin
        m_phase = 1; m_score = 0; m_time = GT; m_pend = 0; m_frames = 0;
      end
    end else if (c) begin
      m_pend = 0;
      finish_race();
    end else if (v) begin
      m_score = imin(m_score + m_pend, MAXS);
      m_pend  = pts;
      m_frames++;
      if (m_frames == FPS) begin
        m_frames = 0;
        m_time--;
        if (m_time == 0) finish_race();
      end
    end else begin
      m_pend = imin(m_pend + pts, 255);
    end
  endtask

  task automatic check_all();
    check_eq("score", int'(score), m_score);
    check_eq("time_left", int'(time_left), m_time);
    check_eq("running", int'(running), (m_phase == 1) ? 1 : 0);
    check_eq("game_over", int'(game_over), (m_phase == 2) ? 1 : 0);
`ifdef RACE_HIGH_SCORE_EN
    check_eq("high_score", int'(high_score), m_hs);
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, check after the next one.
  task automatic cycle(input bit r, s, h, b, c, v);
    rst = r; start = s; hit = h; bonus = b; crash = c; vsync_tick = v;
    model_step(r, s, h, b, c, v);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int tick_pct, bonus_pct;
    rst = 1'b1; start = 1'b0; hit = 1'b0; bonus = 1'b0; crash = 1'b0; vsync_tick = 1'b0;
    @(negedge clk);

    cycle(1, 0, 0, 0, 0, 0);
    check_eq("reset_time", int'(time_left), GT);
    cycle(0, 1, 0, 0, 0, 0);
    check_eq("start_running", int'(running), 1);
    repeat (3) cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    check_eq("pre_tick_score", int'(score), 0);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("tick_score", int'(score), 8);
    cycle(0, 0, 1, 0, 0, 1);
    check_eq("coincident_hit", int'(score), 8);
    cycle(0, 0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 1);
    check_eq("crash_tick_score", int'(score), 8);
    check_eq("crash_over", int'(game_over), 1);
    cycle(0, 1, 0, 0, 0, 0);
    check_eq("restart_score", int'(score), 0);

    for (int epoch = 0; epoch < 60; epoch++) begin
      case (epoch % 3)
        0:       begin tick_pct = 250; bonus_pct = 100; end
        1:       begin tick_pct = 30;  bonus_pct = 600; end
        default: begin tick_pct = 3;   bonus_pct = 800; end
      endcase
      for (int i = 0; i < 200; i++) begin
        cycle($urandom_range(999) < 3,  $urandom_range(999) < 30,
              $urandom_range(999) < 400, $urandom_range(999) < bonus_pct,
              $urandom_range(999) < 10, $urandom_range(999) < tick_pct);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
